// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e  : sequencer state encoding (also visible on state_o)
//   action_e : per-cycle pipeline action selected by the sequencer
//   REG_ZERO : architectural zero register, never a real dependency
//   is_redirect : a control transfer resolved in MEM this cycle
package pipeline_hazard_controller_pkg;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_MEM_WAIT   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      ACT_NONE     = 2'd0,
      ACT_FREEZE   = 2'd1,
      ACT_REDIRECT = 2'd2,
      ACT_BUBBLE   = 2'd3
   } action_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   function automatic logic is_redirect(input logic topc, input logic jmp);
      return topc | jmp;
   endfunction

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detect.sv
// Load-use hazard compare between the instruction in ID and a load in EX.
// Ports:
//   id_rs_i, id_rt_i  : source registers of the ID instruction
//   id_uses_rt_i      : ID instruction actually reads rt
//   ex_mem_read_i     : ID/EX holds a load
//   ex_rt_i           : destination register of that load
//   hazard_o          : ID must wait for the load data
module load_use_detect
   import pipeline_hazard_controller_pkg::*;
(
   input  logic [4:0] id_rs_i,
   input  logic [4:0] id_rt_i,
   input  logic       id_uses_rt_i,
   input  logic       ex_mem_read_i,
   input  logic [4:0] ex_rt_i,
   output logic       hazard_o
);

   // A load into $zero never produces a value anyone can depend on.
   assign hazard_o = ex_mem_read_i & (ex_rt_i != REG_ZERO) &
                     ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Ports:
//   clk, reset             : clock (rising edge), asynchronous active-low reset
//   id_*/ex_* inputs       : operands for the load-use compare
//   mem_topc_i, mem_jmp_i  : branch taken / jump resolved in EX/MEM
//   mem_req_i, mem_ready_i : data-memory access pending / completing
//   *_en_o, *_flush_o      : pipeline register load enables and bubble inserts
//   state_o                : sequencer state (0 RUN, 1 LOAD_STALL, 2 MEM_WAIT)
//   stall_cnt_o            : saturating count of cycles with pc_en_o low
//   flush_cnt_o            : saturating count of redirect events
//   mem_timeout_o          : sticky flag, a memory wait exceeded MEM_TIMEOUT
// Enables/flushes are combinational from state and inputs; state and
// counters update on the rising clock edge.
module pipeline_hazard_controller
   import pipeline_hazard_controller_pkg::*;
#(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int MEM_TIMEOUT       = 16,
   parameter int CNT_W             = 16
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs_i,
   input  logic [4:0]       id_rt_i,
   input  logic             id_uses_rt_i,
   input  logic             ex_mem_read_i,
   input  logic [4:0]       ex_rt_i,
   input  logic             mem_topc_i,
   input  logic             mem_jmp_i,
   input  logic             mem_req_i,
   input  logic             mem_ready_i,
   output logic             pc_en_o,
   output logic             ifid_en_o,
   output logic             idex_en_o,
   output logic             exmem_en_o,
   output logic             memwb_en_o,
   output logic             ifid_flush_o,
   output logic             idex_flush_o,
   output logic             exmem_flush_o,
   output logic             memwb_flush_o,
   output logic [1:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic             mem_timeout_o
);

   localparam int LD_W = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES) : 1;
   localparam int WT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [LD_W-1:0] LD_LAST = LD_W'((LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 1 : 0);
   localparam logic [WT_W-1:0] WT_LAST = WT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic [LD_W-1:0]   ld_cnt_q, ld_cnt_d;
   logic [WT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic              timeout_q, timeout_d;
   action_e           action_s;
   logic              hazard_s;
   logic              mem_wait_s;
   logic              redirect_s;
   logic              timeout_hit_s;

   load_use_detect u_load_use_detect (
      .id_rs_i       (id_rs_i),
      .id_rt_i       (id_rt_i),
      .id_uses_rt_i  (id_uses_rt_i),
      .ex_mem_read_i (ex_mem_read_i),
      .ex_rt_i       (ex_rt_i),
      .hazard_o      (hazard_s)
   );

   assign mem_wait_s    = mem_req_i & ~mem_ready_i;
   assign redirect_s    = is_redirect(mem_topc_i, mem_jmp_i);
   // The wait count already includes the entry cycle, so the limit is one short.
   assign timeout_hit_s = (MEM_TIMEOUT != 0) && (wait_cnt_q >= WT_LAST);

   // Next-state and per-cycle action: memory wait beats redirect beats load-use.
   always_comb begin
      state_d    = state_q;
      ld_cnt_d   = ld_cnt_q;
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
      action_s   = ACT_NONE;
      case (state_q)
         ST_RUN, ST_LOAD_STALL: begin
            if (mem_wait_s) begin
               action_s   = ACT_FREEZE;
               wait_cnt_d = {{(WT_W-1){1'b0}}, 1'b1};
               ld_cnt_d   = '0;
               state_d    = ST_MEM_WAIT;
            end else if (redirect_s) begin
               // A redirect squashes the stalled instruction, so any stall is abandoned.
               action_s = ACT_REDIRECT;
               ld_cnt_d = '0;
               state_d  = ST_RUN;
            end else if (state_q == ST_LOAD_STALL) begin
               action_s = ACT_BUBBLE;
               if (ld_cnt_q >= LD_LAST) begin
                  ld_cnt_d = '0;
                  state_d  = ST_RUN;
               end else begin
                  ld_cnt_d = ld_cnt_q + {{(LD_W-1){1'b0}}, 1'b1};
               end
            end else if (hazard_s) begin
               action_s = ACT_BUBBLE;
               if (LOAD_STALL_CYCLES > 1) begin
                  ld_cnt_d = {{(LD_W-1){1'b0}}, 1'b1};
                  state_d  = ST_LOAD_STALL;
               end else begin
                  ld_cnt_d = '0;
               end
            end else begin
               action_s = ACT_NONE;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ready_i || timeout_hit_s) begin
               // Release cycle: the instruction in MEM may still carry a redirect.
               action_s   = redirect_s ? ACT_REDIRECT : ACT_NONE;
               wait_cnt_d = '0;
               state_d    = ST_RUN;
               if (!mem_ready_i) begin
                  timeout_d = 1'b1;
               end else begin
                  timeout_d = timeout_q;
               end
            end else begin
               action_s = ACT_FREEZE;
               if (wait_cnt_q != {WT_W{1'b1}}) begin
                  wait_cnt_d = wait_cnt_q + {{(WT_W-1){1'b0}}, 1'b1};
               end else begin
                  wait_cnt_d = wait_cnt_q;
               end
            end
         end
         default: begin
            state_d    = ST_RUN;
            ld_cnt_d   = '0;
            wait_cnt_d = '0;
            action_s   = ACT_NONE;
         end
      endcase
   end

   // Output decode; everything held low while reset is asserted.
   always_comb begin
      pc_en_o       = 1'b1;
      ifid_en_o     = 1'b1;
      idex_en_o     = 1'b1;
      exmem_en_o    = 1'b1;
      memwb_en_o    = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_flush_o  = 1'b0;
      exmem_flush_o = 1'b0;
      memwb_flush_o = 1'b0;
      if (!reset) begin
         pc_en_o    = 1'b0;
         ifid_en_o  = 1'b0;
         idex_en_o  = 1'b0;
         exmem_en_o = 1'b0;
         memwb_en_o = 1'b0;
      end else begin
         case (action_s)
            ACT_FREEZE: begin
               pc_en_o       = 1'b0;
               ifid_en_o     = 1'b0;
               idex_en_o     = 1'b0;
               exmem_en_o    = 1'b0;
               memwb_flush_o = 1'b1;
            end
            ACT_REDIRECT: begin
               ifid_flush_o  = 1'b1;
               idex_flush_o  = 1'b1;
               exmem_flush_o = 1'b1;
            end
            ACT_BUBBLE: begin
               pc_en_o      = 1'b0;
               ifid_en_o    = 1'b0;
               idex_flush_o = 1'b1;
            end
            ACT_NONE: begin
               pc_en_o = 1'b1;
            end
            default: begin
               pc_en_o = 1'b1;
            end
         endcase
      end
   end

   // Saturating statistics counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_en_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if ((action_s == ACT_REDIRECT) && (flush_cnt_q != {CNT_W{1'b1}})) begin
         flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         ld_cnt_q    <= '0;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ld_cnt_q    <= ld_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign state_o       = state_q;
   assign stall_cnt_o   = stall_cnt_q;
   assign flush_cnt_o   = flush_cnt_q;
   assign mem_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller. Main instance uses
// LOAD_STALL_CYCLES=1, MEM_TIMEOUT=8; a second instance with
// LOAD_STALL_CYCLES=3 covers multi-cycle load stalls.
module tb_pipeline_hazard_controller;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [4:0] id_rs, id_rt, ex_rt;
   logic       id_uses_rt, ex_mem_read, mem_topc, mem_jmp, mem_req, mem_ready;

   logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic        ifid_fl, idex_fl, exmem_fl, memwb_fl;
   logic [1:0]  state;
   logic [15:0] stall_cnt, flush_cnt;
   logic        mem_to;

   logic        pc_en2, ifid_en2, idex_en2, exmem_en2, memwb_en2;
   logic        ifid_fl2, idex_fl2, exmem_fl2, memwb_fl2;
   logic [1:0]  state2;
   logic [15:0] stall_cnt2, flush_cnt2;
   logic        mem_to2;

   logic [4:0] en_v, en2_v;
   logic [3:0] fl_v, fl2_v;
   assign en_v  = {pc_en, ifid_en, idex_en, exmem_en, memwb_en};
   assign fl_v  = {ifid_fl, idex_fl, exmem_fl, memwb_fl};
   assign en2_v = {pc_en2, ifid_en2, idex_en2, exmem_en2, memwb_en2};
   assign fl2_v = {ifid_fl2, idex_fl2, exmem_fl2, memwb_fl2};

   int n_cmp = 0;
   int n_bad = 0;

   pipeline_hazard_controller #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(8), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
      .ex_mem_read_i(ex_mem_read), .ex_rt_i(ex_rt),
      .mem_topc_i(mem_topc), .mem_jmp_i(mem_jmp), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
      .pc_en_o(pc_en), .ifid_en_o(ifid_en), .idex_en_o(idex_en), .exmem_en_o(exmem_en), .memwb_en_o(memwb_en),
      .ifid_flush_o(ifid_fl), .idex_flush_o(idex_fl), .exmem_flush_o(exmem_fl), .memwb_flush_o(memwb_fl),
      .state_o(state), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .mem_timeout_o(mem_to)
   );

   pipeline_hazard_controller #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(0), .CNT_W(16)) dut2 (
      .clk(clk), .reset(reset),
      .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
      .ex_mem_read_i(ex_mem_read), .ex_rt_i(ex_rt),
      .mem_topc_i(mem_topc), .mem_jmp_i(mem_jmp), .mem_req_i(mem_req), .mem_ready_i(mem_ready),
      .pc_en_o(pc_en2), .ifid_en_o(ifid_en2), .idex_en_o(idex_en2), .exmem_en_o(exmem_en2), .memwb_en_o(memwb_en2),
      .ifid_flush_o(ifid_fl2), .idex_flush_o(idex_fl2), .exmem_flush_o(exmem_fl2), .memwb_flush_o(memwb_fl2),
      .state_o(state2), .stall_cnt_o(stall_cnt2), .flush_cnt_o(flush_cnt2), .mem_timeout_o(mem_to2)
   );

   task automatic idle_inputs();
      id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
      id_uses_rt = 1'b0; ex_mem_read = 1'b0;
      mem_topc = 1'b0; mem_jmp = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      idle_inputs();
      tick();
      tick();
      reset = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_inputs();
      #2;
      n_cmp++; if (en_v !== 5'b00000) begin n_bad++; $display("FAIL rst_en: got %b want %b", en_v, 5'b00000); end
      n_cmp++; if (fl_v !== 4'b0000) begin n_bad++; $display("FAIL rst_fl: got %b want %b", fl_v, 4'b0000); end
      n_cmp++; if ({state, stall_cnt, flush_cnt, mem_to} !== 35'd0) begin n_bad++;
         $display("FAIL rst_regs: got st=%0d sc=%0d fc=%0d to=%b want all 0", state, stall_cnt, flush_cnt, mem_to); end
      tick();
      reset = 1'b1;
      #1;
      n_cmp++; if (en_v !== 5'b11111 || fl_v !== 4'b0000) begin n_bad++;
         $display("FAIL idle_out: got en=%b fl=%b want en=11111 fl=0000", en_v, fl_v); end
   endtask

   task automatic test_load_use();
      do_reset();
      ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
      #1;
      n_cmp++; if (en_v !== 5'b00111) begin n_bad++; $display("FAIL lu_en: got %b want %b", en_v, 5'b00111); end
      n_cmp++; if (fl_v !== 4'b0100) begin n_bad++; $display("FAIL lu_fl: got %b want %b", fl_v, 4'b0100); end
      tick();
      idle_inputs();
      #1;
      n_cmp++; if (en_v !== 5'b11111 || fl_v !== 4'b0000) begin n_bad++;
         $display("FAIL lu_after: got en=%b fl=%b want en=11111 fl=0000", en_v, fl_v); end
      n_cmp++; if (stall_cnt !== 16'd1 || state !== 2'd0) begin n_bad++;
         $display("FAIL lu_cnt: got sc=%0d st=%0d want sc=1 st=0", stall_cnt, state); end
   endtask

   task automatic test_no_hazard();
      do_reset();
      ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
      #1;
      n_cmp++; if (en_v !== 5'b11111) begin n_bad++; $display("FAIL nh_zero: got %b want %b", en_v, 5'b11111); end
      ex_rt = 5'd5; id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
      #1;
      n_cmp++; if (en_v !== 5'b11111) begin n_bad++; $display("FAIL nh_rt_unused: got %b want %b", en_v, 5'b11111); end
      id_uses_rt = 1'b1;
      #1;
      n_cmp++; if (en_v !== 5'b00111) begin n_bad++; $display("FAIL hz_rt_used: got %b want %b", en_v, 5'b00111); end
      ex_mem_read = 1'b0;
      #1;
      n_cmp++; if (en_v !== 5'b11111) begin n_bad++; $display("FAIL nh_no_load: got %b want %b", en_v, 5'b11111); end
      tick();
      n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL nh_cnt: got %0d want 0", stall_cnt); end
   endtask

   task automatic test_redirect();
      do_reset();
      mem_topc = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7;
      #1;
      n_cmp++; if (en_v !== 5'b11111 || fl_v !== 4'b1110) begin n_bad++;
         $display("FAIL rd_topc: got en=%b fl=%b want en=11111 fl=1110", en_v, fl_v); end
      tick();
      idle_inputs();
      mem_jmp = 1'b1;
      #1;
      n_cmp++; if (pc_en !== 1'b1 || fl_v !== 4'b1110) begin n_bad++;
         $display("FAIL rd_jmp: got pc=%b fl=%b want pc=1 fl=1110", pc_en, fl_v); end
      tick();
      idle_inputs();
      #1;
      n_cmp++; if (flush_cnt !== 16'd2 || stall_cnt !== 16'd0 || state !== 2'd0) begin n_bad++;
         $display("FAIL rd_cnt: got fc=%0d sc=%0d st=%0d want fc=2 sc=0 st=0", flush_cnt, stall_cnt, state); end
   endtask

   task automatic test_mem_wait();
      do_reset();
      mem_req = 1'b1; mem_ready = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if (en_v !== 5'b00001 || fl_v !== 4'b0001) begin n_bad++;
            $display("FAIL mw_frz%0d: got en=%b fl=%b want en=00001 fl=0001", k, en_v, fl_v); end
         n_cmp++; if (state !== ((k == 0) ? 2'd0 : 2'd2)) begin n_bad++;
            $display("FAIL mw_st%0d: got %0d want %0d", k, state, (k == 0) ? 0 : 2); end
         tick();
      end
      mem_ready = 1'b1;
      #1;
      n_cmp++; if (en_v !== 5'b11111 || fl_v !== 4'b0000 || state !== 2'd2) begin n_bad++;
         $display("FAIL mw_rel: got en=%b fl=%b st=%0d want en=11111 fl=0000 st=2", en_v, fl_v, state); end
      tick();
      idle_inputs();
      #1;
      n_cmp++; if (state !== 2'd0 || stall_cnt !== 16'd3 || mem_to !== 1'b0) begin n_bad++;
         $display("FAIL mw_end: got st=%0d sc=%0d to=%b want st=0 sc=3 to=0", state, stall_cnt, mem_to); end
   endtask

   task automatic test_priority();
      do_reset();
      mem_req = 1'b1; mem_ready = 1'b0; mem_topc = 1'b1;
      #1;
      n_cmp++; if (en_v !== 5'b00001 || fl_v !== 4'b0001) begin n_bad++;
         $display("FAIL pr_mem_first: got en=%b fl=%b want en=00001 fl=0001", en_v, fl_v); end
      tick();
      mem_ready = 1'b1;
      #1;
      n_cmp++; if (en_v !== 5'b11111 || fl_v !== 4'b1110) begin n_bad++;
         $display("FAIL pr_rel_redirect: got en=%b fl=%b want en=11111 fl=1110", en_v, fl_v); end
      tick();
      idle_inputs();
      #1;
      n_cmp++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1 || state !== 2'd0) begin n_bad++;
         $display("FAIL pr_cnt: got fc=%0d sc=%0d st=%0d want fc=1 sc=1 st=0", flush_cnt, stall_cnt, state); end
   endtask

   task automatic test_timeout();
      do_reset();
      mem_req = 1'b1; mem_ready = 1'b0;
      #1;
      for (int k = 0; k < 7; k++) begin
         n_cmp++; if (en_v !== 5'b00001) begin n_bad++;
            $display("FAIL to_frz%0d: got %b want %b", k, en_v, 5'b00001); end
         tick();
      end
      n_cmp++; if (en_v !== 5'b11111 || state !== 2'd2 || mem_to !== 1'b0) begin n_bad++;
         $display("FAIL to_rel: got en=%b st=%0d to=%b want en=11111 st=2 to=0", en_v, state, mem_to); end
      tick();
      n_cmp++; if (mem_to !== 1'b1 || state !== 2'd0 || stall_cnt !== 16'd7) begin n_bad++;
         $display("FAIL to_flag: got to=%b st=%0d sc=%0d want to=1 st=0 sc=7", mem_to, state, stall_cnt); end
      idle_inputs();
      #1;
   endtask

   task automatic test_reset_mid_wait();
      mem_req = 1'b1; mem_ready = 1'b0;
      #1;
      tick();
      tick();
      n_cmp++; if (state !== 2'd2 || stall_cnt !== 16'd9 || mem_to !== 1'b1) begin n_bad++;
         $display("FAIL rmw_pre: got st=%0d sc=%0d to=%b want st=2 sc=9 to=1", state, stall_cnt, mem_to); end
      reset = 1'b0;
      #1;
      n_cmp++; if (state !== 2'd0 || stall_cnt !== 16'd0 || mem_to !== 1'b0) begin n_bad++;
         $display("FAIL rmw_regs: got st=%0d sc=%0d to=%b want st=0 sc=0 to=0", state, stall_cnt, mem_to); end
      n_cmp++; if (en_v !== 5'b00000 || fl_v !== 4'b0000) begin n_bad++;
         $display("FAIL rmw_out: got en=%b fl=%b want en=00000 fl=0000", en_v, fl_v); end
      tick();
      n_cmp++; if (en_v !== 5'b00000 || state !== 2'd0) begin n_bad++;
         $display("FAIL rmw_hold: got en=%b st=%0d want en=00000 st=0", en_v, state); end
      idle_inputs();
      reset = 1'b1;
      #1;
      n_cmp++; if (en_v !== 5'b11111) begin n_bad++; $display("FAIL rmw_rel: got %b want %b", en_v, 5'b11111); end
   endtask

   task automatic test_multi_stall();
      do_reset();
      ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
      #1;
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if (en2_v !== 5'b00111 || fl2_v !== 4'b0100) begin n_bad++;
            $display("FAIL ms_bub%0d: got en=%b fl=%b want en=00111 fl=0100", k, en2_v, fl2_v); end
         n_cmp++; if (state2 !== ((k == 0) ? 2'd0 : 2'd1)) begin n_bad++;
            $display("FAIL ms_st%0d: got %0d want %0d", k, state2, (k == 0) ? 0 : 1); end
         tick();
      end
      idle_inputs();
      #1;
      n_cmp++; if (en2_v !== 5'b11111 || state2 !== 2'd0 || stall_cnt2 !== 16'd3) begin n_bad++;
         $display("FAIL ms_end: got en=%b st=%0d sc=%0d want en=11111 st=0 sc=3", en2_v, state2, stall_cnt2); end
      // Redirect arriving mid-stall aborts it.
      do_reset();
      ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
      #1;
      tick();
      mem_topc = 1'b1;
      #1;
      n_cmp++; if (en2_v !== 5'b11111 || fl2_v !== 4'b1110 || state2 !== 2'd1) begin n_bad++;
         $display("FAIL ms_abort: got en=%b fl=%b st=%0d want en=11111 fl=1110 st=1", en2_v, fl2_v, state2); end
      tick();
      idle_inputs();
      #1;
      n_cmp++; if (state2 !== 2'd0 || flush_cnt2 !== 16'd1 || stall_cnt2 !== 16'd1) begin n_bad++;
         $display("FAIL ms_abort_cnt: got st=%0d fc=%0d sc=%0d want st=0 fc=1 sc=1", state2, flush_cnt2, stall_cnt2); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_hazard();
      test_redirect();
      test_mem_wait();
      test_priority();
      test_timeout();
      test_reset_mid_wait();
      test_multi_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
